// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> raw magnitude and angle, two micro-rotations per clock.
// Latency: done pulses in the cycle after the 7th rising edge counting the edge that sampled start.
// No backpressure: start is ignored while busy and never queued; a start in the done cycle is accepted.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   start              conversion request, sampled when busy=0 (idle or done cycle)
//   x_in, y_in         signed Q2.16 Cartesian input
//   stage              even stage index driven to the shared atan table (0 when not iterating)
//   atan_in0/atan_in1  atan(2^-stage) and atan(2^-(stage+1)), unsigned Q2.16
//   busy, done         conversion in progress / one-cycle result-update pulse
//   mag_out            unsigned Q4.16 magnitude, uncompensated CORDIC gain included
//   angle_out          signed Q3.16 angle in radians
module cordic_vector #(
    parameter int ITER_PAIRS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] x_in,
    input  logic [17:0] y_in,
    output logic [3:0]  stage,
    input  logic [17:0] atan_in0,
    input  logic [17:0] atan_in1,
    output logic        busy,
    output logic        done,
    output logic [19:0] mag_out,
    output logic [19:0] angle_out
);

    localparam logic [3:0]         LAST_STAGE = 4'(2 * (ITER_PAIRS - 1));
    localparam logic signed [19:0] HALF_PI    = 20'sh1921F;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state, state_nxt;

    logic signed [19:0] x_q, y_q, z_q;
    logic [3:0]         stage_q;
    logic [19:0]        mag_q, ang_q;

    logic signed [19:0] xe, ye, at0, at1;
    logic signed [19:0] x1, y1, z1, x2, y2, z2;
    logic [3:0]         stage_p1;
    logic               load, last;

    assign xe   = {{2{x_in[17]}}, x_in};
    assign ye   = {{2{y_in[17]}}, y_in};
    assign at0  = {2'b00, atan_in0};
    assign at1  = {2'b00, atan_in1};
    assign last = (stage_q == LAST_STAGE);

    // Two chained micro-rotations; the second consumes the first one's results.
    always_comb begin
        stage_p1 = stage_q + 4'd1;
        if (!y_q[19]) begin
            x1 = x_q + (y_q >>> stage_q);
            y1 = y_q - (x_q >>> stage_q);
            z1 = z_q + at0;
        end else begin
            x1 = x_q - (y_q >>> stage_q);
            y1 = y_q + (x_q >>> stage_q);
            z1 = z_q - at0;
        end
        if (!y1[19]) begin
            x2 = x1 + (y1 >>> stage_p1);
            y2 = y1 - (x1 >>> stage_p1);
            z2 = z1 + at1;
        end else begin
            x2 = x1 - (y1 >>> stage_p1);
            y2 = y1 + (x1 >>> stage_p1);
            z2 = z1 - at1;
        end
    end

    // DONE accepts a new start exactly like IDLE so conversions can run back to back.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            stage_q <= '0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else if (load) begin
            stage_q <= '0;
            // Quadrant pre-rotation brings the vector into the right half-plane,
            // where the +/-99.9 degree convergence range of the iterations suffices.
            if (!x_in[17]) begin
                x_q <= xe;
                y_q <= ye;
                z_q <= '0;
            end else if (!y_in[17]) begin
                x_q <= ye;
                y_q <= -xe;
                z_q <= HALF_PI;
            end else begin
                x_q <= -ye;
                y_q <= xe;
                z_q <= -HALF_PI;
            end
        end else if (state == ITER) begin
            x_q <= x2;
            y_q <= y2;
            z_q <= z2;
            if (last) begin
                stage_q <= '0;
                mag_q   <= x2;
                ang_q   <= z2;
            end else begin
                stage_q <= stage_q + 4'd2;
            end
        end
    end

    assign stage     = stage_q;
    assign busy      = (state == ITER);
    assign done      = (state == DONE);
    assign mag_out   = mag_q;
    assign angle_out = ang_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed and random conversions against a reference model.
// Checks handshake timing, stage sequencing, ignored starts, back-to-back starts and async reset.
// Drives the atan table from a real-arithmetic table indexed by the DUT's stage output.
module tb_cordic_vector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] x_in = '0;
    logic [17:0] y_in = '0;
    logic [3:0]  stage;
    logic [17:0] atan_in0 = '0;
    logic [17:0] atan_in1 = '0;
    logic        busy, done;
    logic [19:0] mag_out, angle_out;

    int n_vec = 0;
    int n_err = 0;
    int atan_tab [16];

    cordic_vector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .stage     (stage),
        .atan_in0  (atan_in0),
        .atan_in1  (atan_in1),
        .busy      (busy),
        .done      (done),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    always #5 clk = ~clk;

    // Table lookup settles well before the next rising edge.
    always @(negedge clk) begin
        atan_in0 = 18'(atan_tab[stage]);
        atan_in1 = 18'(atan_tab[stage + 4'd1]);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_vec++;
        assert (d <= tol) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Vectoring CORDIC over iterations 0..11 on plain integers.
    function automatic void model(input int xs, input int ys, output int m, output int a);
        int x, y, z, xn, yn;
        if (xs >= 0) begin
            x = xs;  y = ys;  z = 0;
        end else if (ys >= 0) begin
            x = ys;  y = -xs; z = 'h1921F;
        end else begin
            x = -ys; y = xs;  z = -'h1921F;
        end
        for (int i = 0; i < 12; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
            end else begin
                xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
            end
            x = xn;
            y = yn;
        end
        m = x;
        a = z;
    endfunction

    task automatic start_conv(input int xs, input int ys);
        @(negedge clk);
        x_in  = 18'(xs);
        y_in  = 18'(ys);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Entered just after edge E(e0); returns at the negedge where done=1 (or on timeout).
    task automatic wait_done(input int e0);
        int k;
        k = e0;
        while (k < 20) begin
            @(negedge clk);
            if (done) break;
            chk("busy_iter", int'(busy), 1);
            chk("stage_seq", int'(stage), 2 * k);
            @(posedge clk);
            k++;
        end
        chk("latency_edges", k, 6);
    endtask

    task automatic check_result(input int xs, input int ys);
        int    m, a, ea, d;
        real   r, em;
        model(xs, ys, m, a);
        chk("mag_exact", int'(mag_out), m);
        chk("angle_exact", int'($signed(angle_out)), a);
        chk("busy_at_done", int'(busy), 0);
        r = $sqrt(real'(xs) * real'(xs) + real'(ys) * real'(ys));
        if (r >= 65536.0) begin
            em = 1.6468 * r;
            chk_near("mag_accuracy", int'(mag_out), int'(em), int'(em * 0.001));
            ea = int'($atan2(real'(ys), real'(xs)) * 65536.0);
            d  = int'($signed(angle_out)) - ea;
            if (d > 205887)  d -= 411775;
            if (d < -205887) d += 411775;
            chk_near("angle_accuracy", d, 0, 48);
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("done_pulse_fall", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
        chk("stage_idle", int'(stage), 0);
    endtask

    task automatic convert(input int xs, input int ys);
        start_conv(xs, ys);
        wait_done(0);
        check_result(xs, ys);
        check_idle();
    endtask

    initial begin
        int xs, ys, xb, yb;
        for (int i = 0; i < 16; i++)
            atan_tab[i] = (i < 12) ? int'($atan(1.0 / (2.0 ** i)) * 65536.0) : 0;

        // Reset state
        #12;
        chk("rst_stage", int'(stage), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mag", int'(mag_out), 0);
        chk("rst_angle", int'(angle_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_done", int'(done), 0);

        // Directed points
        convert('h10000, 0);
        chk_near("zero_angle_mag_ref", int'(mag_out), 107922, 108);
        convert('h10000, 'h10000);
        chk_near("deg45_angle_ref", int'($signed(angle_out)), 'h0C910, 48);
        convert(-'h10000, 0);
        chk_near("pi_angle_ref", int'($signed(angle_out)), 'h3243F, 48);
        convert(0, -'h10000);
        chk_near("neg_half_pi_ref", int'($signed(angle_out)), -'h1921F, 48);
        convert(-'h20000, -1);
        convert('h1FFFF, 'h1FFFF);

        // Start pulse at E3 with different inputs is ignored
        start_conv('h8000, -'h12345);
        @(posedge clk);
        @(posedge clk);
        #1;
        x_in  = 18'(-'h1000);
        y_in  = 18'('h1F000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3);
        check_result('h8000, -'h12345);
        check_idle();

        // Start held through the done cycle: second conversion follows immediately
        start_conv(-'h15555, 'h0ABCD);
        wait_done(0);
        check_result(-'h15555, 'h0ABCD);
        x_in  = 18'('h03210);
        y_in  = 18'(-'h1C000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0);
        check_result('h03210, -'h1C000);
        check_idle();

        // Reset at E4 clears everything at once and suppresses done
        start_conv('h11111, 'h07777);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_stage", int'(stage), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_mag", int'(mag_out), 0);
        chk("mid_rst_angle", int'(angle_out), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", int'(done), 0);
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_no_done", int'(done), 0);
        end
        convert(-'h0F00F, -'h1A0A0);

        // Random conversions over the full input range
        for (int n = 0; n < 40; n++) begin
            xb = int'($urandom_range(0, 262143));
            yb = int'($urandom_range(0, 262143));
            xs = xb - 131072;
            ys = yb - 131072;
            convert(xs, ys);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
